// File: rtl/gate_bist_if.sv
// Signal bundle between gate_bist and its controller/gate side.
// Handshake: start is a level request that is honoured only while the engine is idle.
// busy covers the driven vectors, done pulses for one cycle, and the results hold until the next accepted start.
interface gate_bist_if;
    logic       start;
    logic       a;
    logic       b;
    logic       y;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_cnt;
    logic [1:0] err_vec;

    modport master (
        output start, y,
        input  a, b, busy, done, pass, err_cnt, err_vec
    );

    modport slave (
        input  start, y,
        output a, b, busy, done, pass, err_cnt, err_vec
    );
endinterface

// File: rtl/gate_bist.sv
// Built-in self-test for a two-input gate: walks {a,b} through 00..11, holds each vector HOLD_CYCLES, and checks y.
// Define GATE_BIST_STOP_ON_FAIL_EN to end a run on the first mismatch.
module gate_bist #(
    parameter logic [3:0] EXPECTED    = 4'b1000,
    parameter int         HOLD_CYCLES = 50
) (
    input  logic        clk,
    input  logic        rst,
    gate_bist_if.slave  bus,
    output logic [1:0]  dbg_state
);
    localparam int              CW        = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0]   HOLD_LOAD = CW'(HOLD_CYCLES);
`ifdef GATE_BIST_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t          state;
    logic [CW-1:0]   hold_cnt;
    logic [1:0]      vec;
    logic            busy_q;
    logic            done_q;
    logic            pass_q;
    logic [2:0]      err_cnt_q;
    logic [1:0]      err_vec_q;

    logic            mismatch;
    logic [2:0]      err_next;
    logic            last_sample;

    // The hold counter counts down from HOLD_CYCLES; the edge at which it reads 1 ends the vector.
    always_comb begin
        mismatch    = (bus.y != EXPECTED[vec]);
        err_next    = (mismatch && err_cnt_q != 3'd4) ? err_cnt_q + 3'd1 : err_cnt_q;
        last_sample = (vec == 2'b11) || (STOP_ON_FAIL && mismatch);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            vec       <= 2'b00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_cnt_q <= 3'd0;
            err_vec_q <= 2'b00;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state     <= RUN;
                        busy_q    <= 1'b1;
                        vec       <= 2'b00;
                        pass_q    <= 1'b0;
                        err_cnt_q <= 3'd0;
                        err_vec_q <= 2'b00;
                        hold_cnt  <= HOLD_LOAD;
                    end
                end
                RUN: begin
                    if (hold_cnt == CW'(1)) begin
                        err_cnt_q <= err_next;
                        if (mismatch && err_cnt_q == 3'd0) begin
                            err_vec_q <= vec;
                        end
                        if (last_sample) begin
                            state    <= DONE;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            pass_q   <= (err_next == 3'd0);
                            vec      <= 2'b00;
                            hold_cnt <= '0;
                        end else begin
                            vec      <= vec + 2'b01;
                            hold_cnt <= HOLD_LOAD;
                        end
                    end else begin
                        hold_cnt <= hold_cnt - CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.a       = vec[1];
    assign bus.b       = vec[0];
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.pass    = pass_q;
    assign bus.err_cnt = err_cnt_q;
    assign bus.err_vec = err_vec_q;
    assign dbg_state   = state;
endmodule

// File: tb/tb_gate_bist.sv
// Bench for gate_bist: an AND instance (H=4) and an OR instance (H=1) with switchable gate faults.
// Each run's expected {pass, err_cnt, err_vec, done cycle, busy cycles} is queued and checked when done pulses.
module tb_gate_bist;
    logic       clk = 1'b0;
    logic       rst0;
    logic       rst1;
    logic [1:0] dbg0;
    logic [1:0] dbg1;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    logic       stuck0 = 1'b0;
    logic       fault1 = 1'b0;
    int         e0_0 = 0;
    int         busy_cnt0 = 0;
    int         busy_cnt1 = 0;
    int         off0;

    // {pass, err_cnt, err_vec, done_cycle[15:0], busy_cycles[15:0]}
    logic [37:0] exp_q0[$];
    logic [37:0] exp_q1[$];
    logic [37:0] e0_ent;
    logic [37:0] e1_ent;

    gate_bist_if if0 ();
    gate_bist_if if1 ();

    assign if0.y = stuck0 ? 1'b1 : (if0.a & if0.b);
    assign if1.y = (if1.a | if1.b) & ~(fault1 && {if1.a, if1.b} == 2'b10);

    gate_bist #(.EXPECTED(4'b1000), .HOLD_CYCLES(4)) u_and (
        .clk(clk), .rst(rst0), .bus(if0.slave), .dbg_state(dbg0)
    );
    gate_bist #(.EXPECTED(4'b1110), .HOLD_CYCLES(1)) u_or (
        .clk(clk), .rst(rst1), .bus(if1.slave), .dbg_state(dbg1)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor for the AND instance
    always @(negedge clk) begin
        if (rst0) begin
            busy_cnt0 = 0;
        end else begin
            if (if0.busy) begin
                busy_cnt0++;
                off0 = (cyc - e0_0) / 4;
                check("vec0", {if0.a, if0.b}, off0[1:0]);
            end
            if (if0.done) begin
                if (exp_q0.size() == 0) begin
                    check("done0_unexpected", 1, 0);
                end else begin
                    e0_ent = exp_q0.pop_front();
                    check("pass0", if0.pass, e0_ent[37]);
                    check("err_cnt0", if0.err_cnt, e0_ent[36:34]);
                    check("err_vec0", if0.err_vec, e0_ent[33:32]);
                    check("done_cyc0", cyc, e0_ent[31:16]);
                    check("busy_len0", busy_cnt0, e0_ent[15:0]);
                end
                busy_cnt0 = 0;
            end
        end
    end

    // monitor for the OR instance
    always @(negedge clk) begin
        if (rst1) begin
            busy_cnt1 = 0;
        end else begin
            if (if1.busy) busy_cnt1++;
            if (if1.done) begin
                if (exp_q1.size() == 0) begin
                    check("done1_unexpected", 1, 0);
                end else begin
                    e1_ent = exp_q1.pop_front();
                    check("pass1", if1.pass, e1_ent[37]);
                    check("err_cnt1", if1.err_cnt, e1_ent[36:34]);
                    check("err_vec1", if1.err_vec, e1_ent[33:32]);
                    check("done_cyc1", cyc, e1_ent[31:16]);
                    check("busy_len1", busy_cnt1, e1_ent[15:0]);
                end
                busy_cnt1 = 0;
            end
        end
    end

    // driver tasks (called at a negedge)
    task automatic wait_idle0();
        int n = 0;
        while ((if0.busy || if0.done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("idle0_timeout", 1, 0);
    endtask

    task automatic wait_idle1();
        int n = 0;
        while ((if1.busy || if1.done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("idle1_timeout", 1, 0);
    endtask

    task automatic run0(input logic stuck, input logic [5:0] res, input int lat);
        wait_idle0();
        stuck0    = stuck;
        if0.start = 1'b1;
        e0_0      = cyc + 1;
        exp_q0.push_back({res, 16'(e0_0 + lat), 16'(lat)});
        @(negedge clk);
        if0.start = 1'b0;
    endtask

    task automatic run1(input logic flt, input logic [5:0] res, input int lat);
        int e0;
        wait_idle1();
        fault1    = flt;
        if1.start = 1'b1;
        e0        = cyc + 1;
        exp_q1.push_back({res, 16'(e0 + lat), 16'(lat)});
        @(negedge clk);
        if1.start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("drain_timeout", 1, 0);
    endtask

    initial begin
        int e0;
        rst0 = 1'b1;
        rst1 = 1'b1;
        if0.start = 1'b0;
        if1.start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy0", if0.busy, 0);
        check("rst_done0", if0.done, 0);
        check("rst_pass0", if0.pass, 0);
        check("rst_err_cnt0", if0.err_cnt, 0);
        check("rst_err_vec0", if0.err_vec, 0);
        check("rst_ab0", {if0.a, if0.b}, 0);
        check("rst_state0", dbg0, 0);
        check("rst_busy1", if1.busy, 0);
        check("rst_ab1", {if1.a, if1.b}, 0);
        rst0 = 1'b0;
        rst1 = 1'b0;
        @(negedge clk);

        // ideal AND, then stuck-at-1 output
        run0(1'b0, {1'b1, 3'd0, 2'b00}, 16);
        drain();
`ifdef GATE_BIST_STOP_ON_FAIL_EN
        run0(1'b1, {1'b0, 3'd1, 2'b00}, 4);
`else
        run0(1'b1, {1'b0, 3'd3, 2'b00}, 16);
`endif
        drain();

        // ideal OR, then y forced low on vector 10
        run1(1'b0, {1'b1, 3'd0, 2'b00}, 4);
        drain();
`ifdef GATE_BIST_STOP_ON_FAIL_EN
        run1(1'b1, {1'b0, 3'd1, 2'b10}, 3);
`else
        run1(1'b1, {1'b0, 3'd1, 2'b10}, 4);
`endif
        drain();

        // extra start pulses during RUN and DONE are ignored
        run0(1'b0, {1'b1, 3'd0, 2'b00}, 16);
        repeat (3) begin
            @(negedge clk); if0.start = 1'b1;
            @(negedge clk); if0.start = 1'b0;
        end
        begin
            int n = 0;
            while (!if0.done && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) check("done0_wait_timeout", 1, 0);
        end
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        repeat (20) @(negedge clk);
        check("no_extra_done0", exp_q0.size(), 0);
        check("idle_after_ignored0", if0.busy, 0);

        // start held high: back-to-back runs with one IDLE cycle between
        wait_idle1();
        fault1    = 1'b0;
        if1.start = 1'b1;
        e0 = cyc + 1;
        exp_q1.push_back({1'b1, 3'd0, 2'b00, 16'(e0 + 4), 16'd4});
        exp_q1.push_back({1'b1, 3'd0, 2'b00, 16'(e0 + 10), 16'd4});
        repeat (8) @(negedge clk);
        if1.start = 1'b0;
        drain();
        repeat (6) @(negedge clk);

        // reset six cycles into a run aborts it without a done pulse
        wait_idle0();
        stuck0    = 1'b0;
        if0.start = 1'b1;
        e0_0      = cyc + 1;
        @(negedge clk);
        if0.start = 1'b0;
        repeat (6) @(negedge clk);
        check("busy_before_rst0", if0.busy, 1);
        rst0 = 1'b1;
        @(negedge clk);
        check("abort_busy0", if0.busy, 0);
        check("abort_ab0", {if0.a, if0.b}, 0);
        check("abort_err_cnt0", if0.err_cnt, 0);
        check("abort_done0", if0.done, 0);
        check("abort_state0", dbg0, 0);
        rst0 = 1'b0;
        repeat (20) @(negedge clk);
        check("no_done_after_abort0", exp_q0.size(), 0);
        run0(1'b0, {1'b1, 3'd0, 2'b00}, 16);
        drain();
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
